// File: rtl/cpu_mem_pkg.sv
//------------------------------------------------------------------------------
// Module   : cpu_mem_pkg
// Purpose  : Shared state encoding and control constants for the CPU/memory handshake.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic WB_WORD  = 1'b1;
    localparam logic WB_BYTE  = 1'b0;

    localparam int NUM_LANES = 4;
    localparam int BUS_W     = NUM_LANES * 8;

endpackage

`default_nettype wire

// File: rtl/byte_lane_steer.sv
//------------------------------------------------------------------------------
// Module   : byte_lane_steer
// Purpose  : Byte-enable generation, write-data replication and read-lane extraction.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module byte_lane_steer
    import cpu_mem_pkg::*;
(
    input  logic [1:0]       lane,
    input  logic             word_byte,
    input  logic [BUS_W-1:0] wdata_in,
    input  logic [BUS_W-1:0] rdata_in,
    output logic [3:0]       be,
    output logic [BUS_W-1:0] wdata_out,
    output logic [BUS_W-1:0] rdata_out
);

    logic [7:0] lane_byte;

    always_comb begin
        lane_byte = rdata_in[8*lane +: 8];
        if (word_byte == WB_WORD) begin
            be        = 4'hF;
            wdata_out = wdata_in;
            rdata_out = rdata_in;
        end else begin
            be        = 4'b0001 << lane;
            wdata_out = {NUM_LANES{wdata_in[7:0]}};
            rdata_out = {{(BUS_W-8){1'b0}}, lane_byte};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_handshake_unit.sv
//------------------------------------------------------------------------------
// Module   : mem_handshake_unit
// Purpose  : Turns the MFA/MFC handshake into a registered mem_req/mem_ack bus cycle.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_handshake_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MFA,
    input  logic              READ_WRITE,
    input  logic              WORD_BYTE,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              MFC,
    output logic              BusErr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic              wb_q, wb_d;
    logic [1:0]        lane_q, lane_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              mfc_q, mfc_d;
    logic              berr_q, berr_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [1:0]        steer_lane;
    logic              steer_wb;
    logic [3:0]        steer_be;
    logic [DATA_W-1:0] steer_wdata;
    logic [DATA_W-1:0] steer_rdata;

    // While idle the steering sees the live request; afterwards it sees the latched one.
    assign steer_lane = (state_q == IDLE) ? Address[1:0] : lane_q;
    assign steer_wb   = (state_q == IDLE) ? WORD_BYTE    : wb_q;

    byte_lane_steer u_steer (
        .lane      (steer_lane),
        .word_byte (steer_wb),
        .wdata_in  (DataIn),
        .rdata_in  (mem_rdata),
        .be        (steer_be),
        .wdata_out (steer_wdata),
        .rdata_out (steer_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        wb_d    = wb_q;
        lane_d  = lane_q;
        dout_d  = dout_q;
        mfc_d   = mfc_q;
        berr_d  = berr_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (MFA) begin
                    rw_d   = READ_WRITE;
                    wb_d   = WORD_BYTE;
                    lane_d = Address[1:0];
                    if (WORD_BYTE == WB_WORD && Address[1:0] != 2'b00) begin
                        state_d = DONE;
                        mfc_d   = 1'b1;
                        berr_d  = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = 8'd0;
                        req_d   = 1'b1;
                        we_d    = ~READ_WRITE;
                        be_d    = steer_be;
                        addr_d  = {Address[ADDR_W-1:2], 2'b00};
                        wdata_d = steer_wdata;
                    end
                end
            end
            ACCESS: begin
                // An ack on the timeout edge still counts as a successful access.
                if (mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'h0;
                    mfc_d   = 1'b1;
                    berr_d  = 1'b0;
                    if (rw_q == RW_READ) begin
                        dout_d = steer_rdata;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'h0;
                    mfc_d   = 1'b1;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                if (!MFA) begin
                    state_d = IDLE;
                    mfc_d   = 1'b0;
                    berr_d  = 1'b0;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            rw_q    <= 1'b0;
            wb_q    <= 1'b0;
            lane_q  <= 2'b00;
            dout_q  <= '0;
            mfc_q   <= 1'b0;
            berr_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            wb_q    <= wb_d;
            lane_q  <= lane_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            berr_q  <= berr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign DataOut   = dout_q;
    assign MFC       = mfc_q;
    assign BusErr    = berr_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_handshake_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_handshake_unit
// Purpose  : Directed self-checking bench for mem_handshake_unit (TIMEOUT = 4).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_handshake_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MFA;
    logic        READ_WRITE;
    logic        WORD_BYTE;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MFC;
    logic        BusErr;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_assert = 0;
    int n_fail   = 0;
    int req_cycles;

    mem_handshake_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .MFA        (MFA),
        .READ_WRITE (READ_WRITE),
        .WORD_BYTE  (WORD_BYTE),
        .Address    (Address),
        .DataIn     (DataIn),
        .DataOut    (DataOut),
        .MFC        (MFC),
        .BusErr     (BusErr),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b0; MFA = 1'b0; READ_WRITE = 1'b0; WORD_BYTE = 1'b0;
        Address = '0; DataIn = '0; mem_rdata = '0; mem_ack = 1'b0;
        step(); step();
        chk("rst_mfc",     {31'd0, MFC},     32'd0);
        chk("rst_req",     {31'd0, mem_req}, 32'd0);
        chk("rst_be",      {28'd0, mem_be},  32'd0);
        chk("rst_addr",    mem_addr,         32'd0);
        chk("rst_dataout", DataOut,          32'd0);
        Reset = 1'b1;
        step();

        // Word read, ack three cycles after the request
        MFA = 1'b1; READ_WRITE = 1'b1; WORD_BYTE = 1'b1; Address = 32'h0000_0010;
        step();
        chk("wr_req",  {31'd0, mem_req}, 32'd1);
        chk("wr_we",   {31'd0, mem_we},  32'd0);
        chk("wr_be",   {28'd0, mem_be},  32'h0000_000F);
        chk("wr_addr", mem_addr,         32'h0000_0010);
        chk("wr_mfc0", {31'd0, MFC},     32'd0);
        step(); step();
        chk("wr_req_hold", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        chk("wr_mfc",     {31'd0, MFC},     32'd1);
        chk("wr_buserr",  {31'd0, BusErr},  32'd0);
        chk("wr_dataout", DataOut,          32'hDEAD_BEEF);
        chk("wr_req_off", {31'd0, mem_req}, 32'd0);
        step();
        chk("wr_mfc_hold", {31'd0, MFC}, 32'd1);
        MFA = 1'b0;
        step();
        chk("wr_mfc_drop", {31'd0, MFC}, 32'd0);

        // Byte write to lane 3
        MFA = 1'b1; READ_WRITE = 1'b0; WORD_BYTE = 1'b0;
        Address = 32'h0000_0023; DataIn = 32'h0000_00A5;
        step();
        chk("bw_we",    {31'd0, mem_we}, 32'd1);
        chk("bw_be",    {28'd0, mem_be}, 32'h0000_0008);
        chk("bw_addr",  mem_addr,        32'h0000_0020);
        chk("bw_wdata", mem_wdata,       32'hA5A5_A5A5);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("bw_mfc",     {31'd0, MFC},    32'd1);
        chk("bw_buserr",  {31'd0, BusErr}, 32'd0);
        chk("bw_dataout", DataOut,         32'hDEAD_BEEF);
        MFA = 1'b0;
        step();

        // Byte read from lane 1
        MFA = 1'b1; READ_WRITE = 1'b1; WORD_BYTE = 1'b0; Address = 32'h0000_0041;
        step();
        chk("br_be",   {28'd0, mem_be}, 32'h0000_0002);
        chk("br_addr", mem_addr,        32'h0000_0040);
        mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
        step();
        mem_ack = 1'b0;
        chk("br_mfc",     {31'd0, MFC}, 32'd1);
        chk("br_dataout", DataOut,      32'h0000_0033);
        MFA = 1'b0;
        step();

        // Misaligned word access
        MFA = 1'b1; READ_WRITE = 1'b1; WORD_BYTE = 1'b1; Address = 32'h0000_0006;
        step();
        chk("mis_req",    {31'd0, mem_req}, 32'd0);
        chk("mis_mfc",    {31'd0, MFC},     32'd1);
        chk("mis_buserr", {31'd0, BusErr},  32'd1);
        MFA = 1'b0;
        step();
        chk("mis_mfc_drop",    {31'd0, MFC},    32'd0);
        chk("mis_buserr_drop", {31'd0, BusErr}, 32'd0);

        // Timeout with no ack: mem_req high exactly TIMEOUT cycles
        MFA = 1'b1; READ_WRITE = 1'b1; WORD_BYTE = 1'b1; Address = 32'h0000_0100;
        step();
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req !== 1'b1) break;
            req_cycles++;
            step();
        end
        chk("to_req_cycles", 32'(req_cycles),   32'd4);
        chk("to_mfc",        {31'd0, MFC},      32'd1);
        chk("to_buserr",     {31'd0, BusErr},   32'd1);
        chk("to_dataout",    DataOut,           32'h0000_0033);
        MFA = 1'b0;
        step();

        // Ack on the timeout edge wins
        MFA = 1'b1;
        step();
        step(); step(); step();
        chk("toa_req_hold", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ack = 1'b0;
        chk("toa_mfc",     {31'd0, MFC},    32'd1);
        chk("toa_buserr",  {31'd0, BusErr}, 32'd0);
        chk("toa_dataout", DataOut,         32'hCAFE_F00D);
        MFA = 1'b0;
        step();

        // Asynchronous reset in the middle of an access
        MFA = 1'b1; Address = 32'h0000_0200;
        step();
        chk("rma_req", {31'd0, mem_req}, 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("rma_req_off",  {31'd0, mem_req}, 32'd0);
        chk("rma_mfc",      {31'd0, MFC},     32'd0);
        chk("rma_be",       {28'd0, mem_be},  32'd0);
        chk("rma_addr",     mem_addr,         32'd0);
        chk("rma_dataout",  DataOut,          32'd0);
        MFA = 1'b0;
        step();
        Reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        mem_ack = 1'b0;
        chk("late_ack_mfc",     {31'd0, MFC},     32'd0);
        chk("late_ack_req",     {31'd0, mem_req}, 32'd0);
        chk("late_ack_dataout", DataOut,          32'd0);
        step();
        chk("late_ack_idle", {31'd0, MFC}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_handshake_unit.md
Name: mem_handshake_unit

Overview:
- Memory-side partner of the CPU control unit; converts its MFA/MFC request-complete handshake into a registered request/acknowledge cycle on the memory bus.
- Latches address from MAR, write data from MBR, and the READ_WRITE and WORD_BYTE controls. Returns read data for MBR/IR loading.
- Handles byte-lane steering, misalignment and timeout errors.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 4 byte lanes.
- TIMEOUT, 16, maximum cycles waiting for mem_ack before a bus error; 1..255.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- MFA  in  1  memory function request from the control unit.
- READ_WRITE  in  1  1 = read, 0 = write.
- WORD_BYTE  in  1  1 = 32-bit word, 0 = byte.
- Address  in  ADDR_W  MAR contents.
- DataIn  in  DATA_W  MBR contents (write data).
- DataOut  out  DATA_W  read data, valid while MFC=1.
- MFC  out  1  memory function complete.
- BusErr  out  1  access failed (misaligned or timeout); valid while MFC=1.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_W  word-aligned bus address; bits [1:0] are 0.
- mem_wdata  out  DATA_W  lane-steered write data.
- mem_rdata  in  DATA_W  bus read data, valid with mem_ack.
- mem_ack  in  1  one-cycle bus acknowledge.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state = IDLE.
  - Outputs MFC, BusErr, mem_req, mem_we = 0; mem_be = 0; mem_addr, mem_wdata, DataOut = 0.
  - Timeout counter = 0.
  - Reset mid-access drops mem_req immediately. A later mem_ack is ignored.
- All outputs are registered; no combinational path from inputs to outputs.
- State IDLE:
  - On a posedge with MFA=1, capture Address, DataIn, READ_WRITE and WORD_BYTE.
  - If WORD_BYTE=1 and Address[1:0]!=0 (misaligned): go to DONE with MFC=1, BusErr=1; mem_req stays 0.
  - Otherwise go to ACCESS with mem_req=1, mem_we=~READ_WRITE, mem_addr={Address[ADDR_W-1:2],2'b00}.
  - Byte enables: word gives mem_be=4'b1111; byte gives mem_be = 1<<Address[1:0].
  - Write data: word passes DataIn unchanged; byte replicates DataIn[7:0] into all 4 lanes.
- State ACCESS:
  - mem_req and all mem_* outputs are held stable until mem_ack.
  - On mem_ack: mem_req=0, mem_we=0, mem_be=0; go to DONE with MFC=1, BusErr=0.
  - Read data on mem_ack: a word read sets DataOut=mem_rdata. A byte read sets DataOut = zero-extended lane Address[1:0] (little-endian; lane 0 = bits [7:0]). A write leaves DataOut unchanged.
  - The counter increments each cycle without ack. When it reaches TIMEOUT-1 with no ack: drop mem_req, go to DONE with MFC=1, BusErr=1, DataOut unchanged.
  - If mem_ack arrives on the same edge the timeout is reached, mem_ack wins.
- State DONE:
  - MFC held 1 (four-phase handshake) until MFA is sampled 0.
  - Then MFC=0, BusErr=0, counter=0, return to IDLE.
  - A new request needs MFA to return low first; there is no back-to-back without an MFA low cycle.
- Latency: MFA sampled at edge N gives mem_req high after edge N. An ack at edge N+1 gives MFC high after edge N+1. Minimum MFA-to-MFC is 2 edges.
- MFA dropping during ACCESS (protocol violation): the access still completes. DONE then exits on the next cycle, because MFA is already 0.
- mem_ack outside ACCESS is ignored.
- Inputs from the control unit change on negedge Clk. This block samples on posedge, giving a half-cycle setup margin.

Decomposition:
- Shared package cpu_mem_pkg:
  - State encoding IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
  - Constants RW_READ=1, RW_WRITE=0, WB_WORD=1, WB_BYTE=0.
  - Byte-lane count 4.
- One natural sub-module: byte_lane_steer. It is combinational and handles mem_be generation, write-data replication and read-lane extraction from (addr[1:0], WORD_BYTE).
- FSM and timeout counter stay in mem_handshake_unit.

Test Plan:
- Word read: MFA=1, READ_WRITE=1, WORD_BYTE=1, Address=0x0000_0010; memory acks 3 cycles later with 0xDEAD_BEEF -> mem_be=4'hF, mem_addr=0x10, MFC=1, DataOut=0xDEAD_BEEF, BusErr=0. MFC holds until MFA=0, then drops the next cycle.
- Byte write: Address=0x0000_0023, DataIn=0x0000_00A5, READ_WRITE=0, WORD_BYTE=0 -> mem_we=1, mem_be=4'b1000, mem_addr=0x20, mem_wdata=0xA5A5_A5A5, then MFC=1 after ack.
- Byte read: Address=0x0000_0041, mem_rdata=0x1122_3344 -> DataOut=0x0000_0033.
- Misaligned word: Address=0x0000_0006, WORD_BYTE=1 -> mem_req never asserts; MFC=1 and BusErr=1 one edge after MFA is sampled.
- Timeout with TIMEOUT=4 and no ack -> mem_req high for exactly 4 cycles, then MFC=1, BusErr=1. Repeat with ack on the 4th cycle -> BusErr=0.
- Reset mid-access: Reset=0 while mem_req=1 -> all outputs go to 0 immediately. A late mem_ack after Reset=1 is ignored and the state stays IDLE.
